// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, pointer type and Gray helper for the depth-8 async FIFO
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 3;
    localparam int FIFO_PTR_WIDTH  = FIFO_ADDR_WIDTH + 1;

    typedef logic [FIFO_PTR_WIDTH-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// rtl/fifo_gray2bin.sv - combinational XOR-prefix Gray-to-binary converter
module fifo_gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above its position.
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/fifo_rptr_empty.sv
// rtl/fifo_rptr_empty.sv - read-side pointer, empty flag and underflow for the async FIFO
// Optional level / almost-empty outputs are built when FIFO_RD_LEVEL_EN is defined.
module fifo_rptr_empty
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
`ifdef FIFO_RD_LEVEL_EN
    ,
    parameter int AE_THRESH  = 2
`endif
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  r_inc,
    input  logic [ADDR_WIDTH:0]   r_wptr_sync,
    input  logic                  r_clr_err,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   r_ptr,
    output logic                  r_empty,
    output logic                  r_underflow
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   r_level,
    output logic                  r_almost_empty
`endif
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] bin_q, bin_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          empty_q, empty_d;
    logic          underflow_q, underflow_d;
    logic          rd_fire;

    always_comb begin
        rd_fire     = r_inc & ~empty_q;
        bin_d       = bin_q + {{ADDR_WIDTH{1'b0}}, rd_fire};
        ptr_d       = bin_d ^ (bin_d >> 1);
        // Compare the next pointer so the flag is registered without an extra cycle.
        empty_d     = (ptr_d == r_wptr_sync);
        underflow_d = underflow_q;
        if (r_clr_err) begin
            underflow_d = 1'b0;
        end
        if (r_inc & empty_q) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            bin_q       <= '0;
            ptr_q       <= '0;
            empty_q     <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            bin_q       <= bin_d;
            ptr_q       <= ptr_d;
            empty_q     <= empty_d;
            underflow_q <= underflow_d;
        end
    end

    assign r_addr      = bin_q[ADDR_WIDTH-1:0];
    assign r_ptr       = ptr_q;
    assign r_empty     = empty_q;
    assign r_underflow = underflow_q;

`ifdef FIFO_RD_LEVEL_EN
    localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] level_q, level_d;
    logic          almost_empty_q, almost_empty_d;

    fifo_gray2bin #(
        .WIDTH (PW)
    ) u_wptr_g2b (
        .gray (r_wptr_sync),
        .bin  (wbin)
    );

    // The synchronized write pointer lags, so this can only under-report.
    always_comb begin
        level_d        = wbin - bin_d;
        almost_empty_d = (level_d <= AE_LIMIT);
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            level_q        <= '0;
            almost_empty_q <= 1'b1;
        end else begin
            level_q        <= level_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign r_level        = level_q;
    assign r_almost_empty = almost_empty_q;
`endif

endmodule
